// File: rtl/alu_seq_pkg.sv
// Shared constants, state encoding and response payload for the ALU command sequencer.
package alu_seq_pkg;

  localparam int unsigned DATA_W    = 4;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned CTRL_W    = 9;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned LAT_CNT_W = 2;

  // Legal range of the ALU_LAT parameter (limited by the 2-bit EXEC counter).
  localparam int unsigned ALU_LAT_MIN = 1;
  localparam int unsigned ALU_LAT_MAX = 4;

  // Opcodes.
  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_LSR = 4'd2;
  localparam logic [OP_W-1:0] OP_LSH = 4'd3;
  localparam logic [OP_W-1:0] OP_RSH = 4'd4;
  localparam logic [OP_W-1:0] OP_AND = 4'd5;
  localparam logic [OP_W-1:0] OP_OR  = 4'd6;
  localparam logic [OP_W-1:0] OP_XOR = 4'd7;
  localparam logic [OP_W-1:0] OP_INV = 4'd8;

  // Bit positions inside the one-hot ALU control word.
  localparam int unsigned BIT_ADD = 0;
  localparam int unsigned BIT_SUB = 1;
  localparam int unsigned BIT_LSR = 2;
  localparam int unsigned BIT_LSH = 3;
  localparam int unsigned BIT_RSH = 4;
  localparam int unsigned BIT_AND = 5;
  localparam int unsigned BIT_OR  = 6;
  localparam int unsigned BIT_XOR = 7;
  localparam int unsigned BIT_INV = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              ovf;
    logic              err;
  } rsp_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational opcode decoder: 4-bit opcode to 9-bit one-hot ALU control plus illegal flag.
module alu_op_decoder
  import alu_seq_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  output logic [CTRL_W-1:0] onehot_c_o,
  output logic              illegal_c_o
);

  // Opcode to one-hot mapping; opcodes above INV are illegal and drive no control bit.
  always_comb begin
    onehot_c_o  = '0;
    illegal_c_o = 1'b0;
    case (op_i)
      OP_ADD:  onehot_c_o[BIT_ADD] = 1'b1;
      OP_SUB:  onehot_c_o[BIT_SUB] = 1'b1;
      OP_LSR:  onehot_c_o[BIT_LSR] = 1'b1;
      OP_LSH:  onehot_c_o[BIT_LSH] = 1'b1;
      OP_RSH:  onehot_c_o[BIT_RSH] = 1'b1;
      OP_AND:  onehot_c_o[BIT_AND] = 1'b1;
      OP_OR:   onehot_c_o[BIT_OR]  = 1'b1;
      OP_XOR:  onehot_c_o[BIT_XOR] = 1'b1;
      OP_INV:  onehot_c_o[BIT_INV] = 1'b1;
      default: illegal_c_o         = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_command_sequencer.sv
// ALU command sequencer: accepts a command, holds the one-hot ALU control for ALU_LAT
// cycles, captures the result and presents it until the consumer takes it.
// Optional build macro ALU_SEQ_PERF_EN adds an 8-bit saturating response counter (cmd_count).
module alu_command_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_ovf,
  output logic              rsp_err
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0]  cmd_count
`endif
);

  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(ALU_LAT - 1);

  state_e                 state_q, state_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
  logic [DATA_W-1:0]      in1_q, in1_d;
  logic [DATA_W-1:0]      in2_q, in2_d;
  rsp_t                   rsp_q, rsp_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic [CTRL_W-1:0]      dec_onehot;
  logic                   dec_illegal;
`ifdef ALU_SEQ_PERF_EN
  logic [CNT_W-1:0]       count_q, count_d;
`endif

  alu_op_decoder u_dec (
    .op_i        (cmd_op),
    .onehot_c_o  (dec_onehot),
    .illegal_c_o (dec_illegal)
  );

  // State and output registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ctrl_q      <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
`ifdef ALU_SEQ_PERF_EN
      count_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
`ifdef ALU_SEQ_PERF_EN
      count_q     <= count_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_d      = ctrl_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
`ifdef ALU_SEQ_PERF_EN
    count_d     = count_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          in1_d = cmd_a;
          in2_d = cmd_b;
          cnt_d = '0;
          if (dec_illegal) begin
            ctrl_d      = '0;
            rsp_d.data  = '0;
            rsp_d.ovf   = 1'b0;
            rsp_d.err   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            ctrl_d  = dec_onehot;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == LAT_LAST) begin
          ctrl_d      = '0;
          // LSR is a pass-through of operand A; the ALU result is not used.
          rsp_d.data  = ctrl_q[BIT_LSR] ? in1_q : alu_out;
          rsp_d.ovf   = (ctrl_q[BIT_ADD] | ctrl_q[BIT_SUB]) & alu_overflow;
          rsp_d.err   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + LAT_CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
`ifdef ALU_SEQ_PERF_EN
          if (count_q != '1) begin
            count_d = count_q + CNT_W'(1);
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_ctrl  = ctrl_q;
  assign alu_in1   = in1_q;
  assign alu_in2   = in2_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_q.data;
  assign rsp_ovf   = rsp_q.ovf;
  assign rsp_err   = rsp_q.err;
`ifdef ALU_SEQ_PERF_EN
  assign cmd_count = count_q;
`endif

endmodule

// File: tb/tb_alu_command_sequencer.sv
// Directed bench: three sequencers (ALU_LAT = 1, 2, 4), each with a latency-aware ALU model
// that returns corrupted data until its control has been held for ALU_LAT cycles.
module tb_alu_command_sequencer;

  logic       clk;
  logic       reset;
  logic [2:0] cmd_valid_v;
  logic [3:0] cmd_op, cmd_a, cmd_b;
  logic       rsp_ready;

  logic       cmd_ready_v [3];
  logic [8:0] alu_ctrl_v  [3];
  logic [3:0] in1_v       [3];
  logic [3:0] in2_v       [3];
  logic [3:0] alu_out_v   [3];
  logic       alu_ovf_v   [3];
  logic       rsp_valid_v [3];
  logic [3:0] rsp_data_v  [3];
  logic       rsp_ovf_v   [3];
  logic       rsp_err_v   [3];
`ifdef ALU_SEQ_PERF_EN
  logic [7:0] cmd_count_v [3];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic [3:0]  res;
    logic        ov;
    int unsigned hold;

    alu_command_sequencer #(.ALU_LAT(LAT)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid_v[g]),
      .cmd_ready    (cmd_ready_v[g]),
      .cmd_op       (cmd_op),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .alu_ctrl     (alu_ctrl_v[g]),
      .alu_in1      (in1_v[g]),
      .alu_in2      (in2_v[g]),
      .alu_out      (alu_out_v[g]),
      .alu_overflow (alu_ovf_v[g]),
      .rsp_valid    (rsp_valid_v[g]),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data_v[g]),
      .rsp_ovf      (rsp_ovf_v[g]),
      .rsp_err      (rsp_err_v[g])
`ifdef ALU_SEQ_PERF_EN
      ,
      .cmd_count    (cmd_count_v[g])
`endif
    );

    // ALU model: carry/borrow as overflow for ADD/SUB, overflow forced high otherwise.
    always_comb begin
      res = 4'h0;
      ov  = 1'b1;
      case (alu_ctrl_v[g])
        9'h001:  {ov, res} = {1'b0, in1_v[g]} + {1'b0, in2_v[g]};
        9'h002:  begin res = in1_v[g] - in2_v[g]; ov = (in1_v[g] < in2_v[g]); end
        9'h004:  res = 4'hF;
        9'h008:  res = {in1_v[g][2:0], 1'b0};
        9'h010:  res = {1'b0, in1_v[g][3:1]};
        9'h020:  res = in1_v[g] & in2_v[g];
        9'h040:  res = in1_v[g] | in2_v[g];
        9'h080:  res = in1_v[g] ^ in2_v[g];
        9'h100:  res = ~in1_v[g];
        default: res = 4'h0;
      endcase
    end

    // Cycles the control has been held; outputs are inverted until the latency is met.
    always @(posedge clk or negedge reset) begin
      if (!reset)                  hold <= 0;
      else if (alu_ctrl_v[g] != 0) hold <= hold + 1;
      else                         hold <= 0;
    end

    assign alu_out_v[g] = (hold + 1 >= LAT) ? res : ~res;
    assign alu_ovf_v[g] = (hold + 1 >= LAT) ? ov  : ~ov;
  end

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  // Issue one command on instance k and follow it through to its response handshake.
  // If pend is set, a new command is presented during the stall and left asserted.
  task automatic run_cmd(input int k, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] exp_d, input logic exp_o,
                         input logic exp_e, input int stall, input bit pend,
                         input logic [3:0] p_op);
    int         waited;
    logic [8:0] exp_ctrl;
    waited   = 0;
    exp_ctrl = exp_e ? 9'h000 : (9'h001 << op);
    cmd_valid_v[k] = 1'b1;
    cmd_op = op;
    cmd_a  = a;
    cmd_b  = b;
    while (!cmd_ready_v[k] && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("accept_timeout", 32'(waited < 20), 32'd1);
    @(posedge clk); #1;
    cmd_valid_v[k] = 1'b0;
    if (exp_e) begin
      check("illegal_ctrl", 32'(alu_ctrl_v[k]), 32'h0);
    end else begin
      for (int c = 0; c < lat_of(k); c++) begin
        check("exec_ctrl", 32'(alu_ctrl_v[k]), 32'(exp_ctrl));
        check("exec_rsp_valid", 32'(rsp_valid_v[k]), 32'd0);
        check("exec_cmd_ready", 32'(cmd_ready_v[k]), 32'd0);
        @(posedge clk); #1;
      end
      check("resp_ctrl", 32'(alu_ctrl_v[k]), 32'h0);
    end
    check("rsp_valid", 32'(rsp_valid_v[k]), 32'd1);
    check("rsp_data", 32'(rsp_data_v[k]), 32'(exp_d));
    check("rsp_ovf", 32'(rsp_ovf_v[k]), 32'(exp_o));
    check("rsp_err", 32'(rsp_err_v[k]), 32'(exp_e));
    if (pend) begin
      cmd_valid_v[k] = 1'b1;
      cmd_op = p_op;
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(rsp_valid_v[k]), 32'd1);
      check("stall_data", 32'(rsp_data_v[k]), 32'(exp_d));
      check("stall_cmd_ready", 32'(cmd_ready_v[k]), 32'd0);
      check("stall_ctrl", 32'(alu_ctrl_v[k]), 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_hs_valid", 32'(rsp_valid_v[k]), 32'd0);
    check("post_hs_ready", 32'(cmd_ready_v[k]), 32'd1);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    cmd_valid_v = 3'b000;
    cmd_op      = 4'h0;
    cmd_a       = 4'h0;
    cmd_b       = 4'h0;
    rsp_ready   = 1'b0;
    #12;
    // Values while reset is held low.
    for (int k = 0; k < 3; k++) begin
      check("rst_cmd_ready", 32'(cmd_ready_v[k]), 32'd0);
      check("rst_ctrl", 32'(alu_ctrl_v[k]), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid_v[k]), 32'd0);
      check("rst_in1", 32'(in1_v[k]), 32'h0);
      check("rst_rsp_data", 32'(rsp_data_v[k]), 32'h0);
    end
    #10 reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(cmd_ready_v[0]), 32'd1);
`ifdef ALU_SEQ_PERF_EN
    check("count_rst", 32'(cmd_count_v[0]), 32'd0);
`endif

    // inst, op, a, b, exp data, exp ovf, exp err, stall, pend, pend op
    run_cmd(0, 4'd0, 4'b0111, 4'b0101, 4'b1100, 1'b0, 1'b0, 0, 1'b0, 4'd0); // ADD, LAT1
    run_cmd(1, 4'd1, 4'b0111, 4'b0101, 4'b0010, 1'b0, 1'b0, 0, 1'b0, 4'd0); // SUB, LAT2
    run_cmd(2, 4'd1, 4'b0101, 4'b0111, 4'b1110, 1'b1, 1'b0, 1, 1'b0, 4'd0); // SUB borrow, LAT4
    run_cmd(0, 4'd0, 4'b1100, 4'b0101, 4'b0001, 1'b1, 1'b0, 0, 1'b0, 4'd0); // ADD carry
    run_cmd(1, 4'd2, 4'b0111, 4'b0011, 4'b0111, 1'b0, 1'b0, 0, 1'b0, 4'd0); // LSR
    run_cmd(2, 4'd2, 4'b0111, 4'b0000, 4'b0111, 1'b0, 1'b0, 0, 1'b0, 4'd0); // LSR, LAT4
    run_cmd(0, 4'd12, 4'b0111, 4'b0101, 4'b0000, 1'b0, 1'b1, 2, 1'b0, 4'd0); // illegal 12
    run_cmd(2, 4'd15, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1, 0, 1'b0, 4'd0); // illegal 15
    run_cmd(1, 4'd3, 4'b0011, 4'b0000, 4'b0110, 1'b0, 1'b0, 0, 1'b0, 4'd0); // LSH
    run_cmd(1, 4'd4, 4'b1010, 4'b0000, 4'b0101, 1'b0, 1'b0, 0, 1'b0, 4'd0); // RSH
    run_cmd(2, 4'd6, 4'b1010, 4'b0101, 4'b1111, 1'b0, 1'b0, 0, 1'b0, 4'd0); // OR
    run_cmd(0, 4'd8, 4'b0110, 4'b0000, 4'b1001, 1'b0, 1'b0, 0, 1'b0, 4'd0); // INV
    // AND with a 5-cycle stall; XOR presented during the stall must wait, then be taken.
    run_cmd(0, 4'd5, 4'b0111, 4'b0101, 4'b0101, 1'b0, 1'b0, 5, 1'b1, 4'd7);
    run_cmd(0, 4'd7, 4'b0111, 4'b0101, 4'b0010, 1'b0, 1'b0, 0, 1'b0, 4'd0); // XOR

    // Reset in the middle of EXEC on the LAT4 instance aborts the command.
    cmd_valid_v[2] = 1'b1;
    cmd_op = 4'd0;
    cmd_a  = 4'b0011;
    cmd_b  = 4'b0001;
    @(posedge clk); #1;
    cmd_valid_v[2] = 1'b0;
    @(posedge clk); #1;
    check("mid_exec_ctrl", 32'(alu_ctrl_v[2]), 32'h001);
    reset = 1'b0;
    #1;
    check("abort_ctrl", 32'(alu_ctrl_v[2]), 32'h0);
    check("abort_in1", 32'(in1_v[2]), 32'h0);
    check("abort_in2", 32'(in2_v[2]), 32'h0);
    check("abort_ready", 32'(cmd_ready_v[2]), 32'd0);
    check("abort_valid", 32'(rsp_valid_v[2]), 32'd0);
    check("abort_data_other", 32'(rsp_data_v[0]), 32'h0);
    @(posedge clk); #3;
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("no_rsp_after_abort", 32'(rsp_valid_v[2]), 32'd0);
      check("no_ctrl_after_abort", 32'(alu_ctrl_v[2]), 32'h0);
    end
    check("ready_after_abort", 32'(cmd_ready_v[2]), 32'd1);

`ifdef ALU_SEQ_PERF_EN
    check("count_after_abort", 32'(cmd_count_v[2]), 32'd0);
    // Back-to-back illegal commands with the consumer always ready; well over 255 handshakes.
    cmd_valid_v[0] = 1'b1;
    cmd_op    = 4'd12;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
    end
    check("count_running", 32'(cmd_count_v[0] != 8'd0), 32'd1);
    for (int c = 0; c < 1200; c++) begin
      @(posedge clk); #1;
    end
    check("count_saturate", 32'(cmd_count_v[0]), 32'd255);
    cmd_valid_v[0] = 1'b0;
    rsp_ready = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_command_sequencer.md
ALU_COMMAND_SEQUENCER -- requirements
Module: alu_command_sequencer

Interface
REQ-001 Parameter ALU_LAT, default 1: cycles the ALU control must be held before alu_out/alu_overflow are valid; legal range 1..4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_op  input  4  opcode: 0 ADD, 1 SUB, 2 LSR, 3 LSH, 4 RSH, 5 AND, 6 OR, 7 XOR, 8 INV, 9..15 illegal.
REQ-007 cmd_a, cmd_b  input  4 each  operands.
REQ-008 alu_ctrl  output  9  one-hot ALU control, bit0 ADD .. bit8 INV, in opcode order.
REQ-009 alu_in1, alu_in2  output  4 each  registered operands to ALU.
REQ-010 alu_out  input  4  ALU result.
REQ-011 alu_overflow  input  1  ALU overflow flag.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_data  output  4  captured result.
REQ-015 rsp_ovf  output  1  captured overflow (ADD/SUB only, else 0).
REQ-016 rsp_err  output  1  illegal opcode flag.

Function
REQ-017 FSM states IDLE, EXEC, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: on cmd_valid&&cmd_ready at edge N, register op/a/b; legal op -> EXEC, illegal op -> RESP.
REQ-019 EXEC: alu_ctrl SHALL carry exactly one set bit for exactly ALU_LAT cycles following edge N; alu_ctrl SHALL be 0 in every other state.
REQ-020 At edge N+ALU_LAT, rsp_data<=alu_out, rsp_ovf<=alu_overflow for ADD/SUB else 0, rsp_err<=0; go RESP.
REQ-021 LSR: rsp_data SHALL be the registered cmd_a (ALU output not sampled), rsp_ovf=0.
REQ-022 Illegal op: alu_ctrl stays 0, rsp_data=0, rsp_ovf=0, rsp_err=1, rsp_valid from edge N+1 onward.
REQ-023 RESP: rsp_valid=1 and rsp_* held stable until rsp_valid&&rsp_ready; then IDLE, cmd_ready=1 the following cycle (no same-cycle accept).
REQ-024 cmd_valid in EXEC/RESP SHALL be ignored; no command lost when producer holds cmd_valid until accepted.
REQ-025 EXEC cycle counter SHALL be 2 bits; wraps never observed since ALU_LAT<=4.

Reset
REQ-026 reset low SHALL immediately force IDLE, cmd_ready=1 only after reset release, alu_ctrl=0, alu_in1/in2=0, rsp_valid=0, rsp_data=0, rsp_ovf=0, rsp_err=0.
REQ-027 Reset asserted in EXEC or RESP SHALL abort the command; no response emitted for it.

Configuration
REQ-028 Macro ALU_SEQ_PERF_EN: when defined, add output cmd_count (8 bits), incremented on each response handshake, saturating at 255, reset to 0.
REQ-029 Without ALU_SEQ_PERF_EN, cmd_count port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-030 Package alu_seq_pkg SHALL hold opcode constants, one-hot bit indices, FSM state encoding, and ALU_LAT bounds.
REQ-031 Sub-module alu_op_decoder SHALL map 4-bit opcode to 9-bit one-hot plus illegal flag (combinational); sequencer registers its output.

Verification
REQ-032 ALU_LAT=1, a=0111 b=0101 op=ADD -> alu_ctrl=000000001 for 1 cycle, rsp_data=1100, rsp_valid one cycle after ALU_LAT elapses.
REQ-033 Same operands, op=SUB, ALU_LAT=2 -> alu_ctrl=000000010 exactly 2 cycles, rsp_data=0010, rsp_ovf as driven by ALU model.
REQ-034 op=LSR a=0111 -> alu_ctrl=000000100 for ALU_LAT cycles, rsp_data=0111, rsp_ovf=0.
REQ-035 op=12 -> alu_ctrl never nonzero, rsp_err=1, rsp_data=0, rsp_valid at N+1.
REQ-036 rsp_ready held low 5 cycles after AND (0111&0101) -> rsp_data=0101 stable, cmd_ready=0, new cmd_valid ignored until handshake.
REQ-037 reset low mid-EXEC -> all outputs zero immediately, no response; with ALU_SEQ_PERF_EN, cmd_count=0 and saturates at 255 after 300 commands.
